// File: rtl/instr_mem_responder.sv
// Instruction memory responder: a program-loadable word array answering PC fetches
// over a valid/ready request/response pair after a fixed number of wait cycles.
module instr_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_instr,
  output logic                           rsp_err,
  input  logic                           load_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data,
  output logic                           load_overrun
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = 4;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        addr_q;
  logic [31:0]        mem [DEPTH_WORDS];

  logic               accept_c;
  logic               rsp_load_c;
  logic [31:0]        fetch_addr_c;
  logic               fetch_err_c;
  logic [AW-1:0]      fetch_idx_c;

  // Load strobes steal the request slot so the memory port is never shared.
  assign req_ready = (state_q == IDLE) && !load_we;
  assign accept_c  = req_valid && req_ready;

  // With zero wait cycles RESP is entered straight from IDLE, so read the live address.
  assign fetch_addr_c = (state_q == IDLE) ? req_addr : addr_q;
  assign fetch_idx_c  = fetch_addr_c[AW+1:2];
  assign fetch_err_c  = (fetch_addr_c[1:0] != 2'b00) ||
                        (fetch_addr_c[31:2] >= 30'(DEPTH_WORDS));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept_c) state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT: if (cnt_q <= CNT_W'(1)) state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rsp_load_c = (state_d == RESP) && (state_q != RESP);

  // State, counter and registered response/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      rsp_valid    <= 1'b0;
      rsp_instr    <= '0;
      rsp_err      <= 1'b0;
      load_overrun <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= (state_d == RESP);
      if (accept_c) begin
        addr_q <= req_addr;
        cnt_q  <= CNT_W'(WAIT_CYCLES);
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (rsp_load_c) begin
        rsp_err   <= fetch_err_c;
        rsp_instr <= fetch_err_c ? NOP : mem[fetch_idx_c];
      end
      if (load_we && state_q != IDLE) load_overrun <= 1'b1;
    end
  end

  // Program store: no reset, writes only while idle.
  always_ff @(posedge clk) begin
    if (load_we && state_q == IDLE) mem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder: loads a small program, fetches it back
// and exercises error, stall, overrun, load/request collision and mid-fetch reset.
module tb_instr_mem_responder;

  localparam int unsigned DEPTH_WORDS = 64;
  localparam int unsigned WAIT_CYCLES = 1;
  localparam int unsigned AW          = $clog2(DEPTH_WORDS);
  localparam logic [31:0] NOP         = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_instr;
  logic          rsp_err;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          load_overrun;

  int n_cmp = 0;
  int n_mis = 0;
  logic [32:0] sb [$];
  logic [31:0] prog [4];

  instr_mem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_err(rsp_err),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .load_overrun(load_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [32:0] e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_instr"}, rsp_instr, e[31:0]);
      check({tag, "_err"}, 32'(rsp_err), 32'(e[32]));
    end
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  // Bounded wait for rsp_valid; returns cycles since the accept cycle.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_fetch(input string tag, input logic [31:0] a,
                          input logic [31:0] ei, input logic ee);
    int lat;
    req_addr = a; req_valid = 1'b1;
    #1;
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    sb.push_back({ee, ei});
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(lat);
    check({tag, "_latency"}, 32'(lat), 32'(WAIT_CYCLES + 1));
    if (rsp_valid) pop_check(tag);
    @(negedge clk);
    check({tag, "_idle"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [31:0] held;
    prog[0] = 32'h0020_81B3; prog[1] = 32'h4020_81B3;
    prog[2] = 32'h0020_E1B3; prog[3] = 32'h0020_F1B3;
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    load_we = 1'b0; load_addr = '0; load_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_instr", rsp_instr, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_overrun", 32'(load_overrun), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);

    // Program load and in-order fetch
    for (int i = 0; i < 4; i++) do_load(AW'(i), prog[i]);
    for (int i = 0; i < 4; i++) do_fetch("fetch", 32'(4 * i), prog[i], 1'b0);

    // Misaligned and out-of-range
    do_fetch("misalign", 32'h0000_0006, NOP, 1'b1);
    do_fetch("oor", 32'(4 * DEPTH_WORDS), NOP, 1'b1);

    // Consumer stall in RESP
    rsp_ready = 1'b0;
    req_addr = 32'd8; req_valid = 1'b1;
    sb.push_back({1'b0, prog[2]});
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(lat);
    check("stall_latency", 32'(lat), 32'(WAIT_CYCLES + 1));
    held = rsp_instr;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_instr", rsp_instr, held);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check("stall_valid_end", 32'(rsp_valid), 32'd1);
    pop_check("stall");
    @(negedge clk);
    check("stall_release_valid", 32'(rsp_valid), 32'd0);
    check("stall_release_ready", 32'(req_ready), 32'd1);

    // Load attempted while busy is dropped and flagged
    req_addr = 32'd0; req_valid = 1'b1;
    sb.push_back({1'b0, prog[0]});
    @(negedge clk);
    req_valid = 1'b0;
    load_we = 1'b1; load_addr = '0; load_data = 32'hDEAD_BEEF;
    check("ovr_in_wait", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    load_we = 1'b0;
    check("ovr_flag", 32'(load_overrun), 32'd1);
    check("ovr_rsp_valid", 32'(rsp_valid), 32'd1);
    if (rsp_valid) pop_check("ovr");
    @(negedge clk);
    do_fetch("ovr_refetch", 32'd0, prog[0], 1'b0);
    check("ovr_sticky", 32'(load_overrun), 32'd1);

    // Load and request in the same idle cycle: load wins, request goes next cycle
    load_we = 1'b1; load_addr = AW'(3); load_data = 32'h1234_5678;
    req_addr = 32'd12; req_valid = 1'b1;
    #1;
    check("collide_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    load_we = 1'b0;
    check("collide_not_accepted", 32'(rsp_valid), 32'd0);
    do_fetch("collide", 32'd12, 32'h1234_5678, 1'b0);

    // Reset mid-WAIT abandons the fetch
    req_addr = 32'd4; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rstwait_valid", 32'(rsp_valid), 32'd0);
    check("rstwait_overrun", 32'(load_overrun), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("rstwait_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    do_fetch("post_rst", 32'd0, prog[0], 1'b0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
